// File: rtl/conv_line_buffer.sv
// Three-row column feeder for a 3x3 convolution array: two line memories hold the
// previous two rows so each accepted pixel emits the vertically aligned triple above it.
module conv_line_buffer #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int COL_W      = 7,
  parameter int ROW_W      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic       out_valid,
  output logic       out_eol,
  output logic       out_eof,
  output logic       frame_done
);

  typedef enum logic {
    FILL,
    STREAM
  } state_e;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [7:0] lb_top [IMG_WIDTH];
  logic [7:0] lb_mid [IMG_WIDTH];

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       x1_q, x2_q, x3_q;
  logic             out_valid_q, out_eol_q, out_eof_q, frame_done_q;

  logic last_col;
  logic last_row;
  logic stream_pix;

  assign last_col   = (col_q == LAST_COL);
  assign last_row   = (row_q == LAST_ROW);
  assign stream_pix = in_valid && (state_q == STREAM);

  // Counters wrap at the parameter value, so non-power-of-two geometries work.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (in_valid) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      if (last_col) begin
        row_d = last_row ? '0 : row_q + 1'b1;
      end
      case (state_q)
        FILL:    if (last_col && row_q == ROW_ONE) state_d = STREAM;
        STREAM:  if (last_col && last_row)         state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: line memories carry no reset; stale contents are masked because the
  // first two rows after reset or end-of-frame always pass through FILL.
  always_ff @(posedge clock) begin
    if (in_valid && !reset) begin
      lb_top[col_q] <= lb_mid[col_q];
      lb_mid[col_q] <= in_data;
    end
  end

  // NOTE: non-blocking assignments give read-before-write: x1/x2 capture the
  // old lb_top/lb_mid words even though the same column is rewritten this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      out_valid_q  <= 1'b0;
      out_eol_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= stream_pix;
      out_eol_q    <= stream_pix && last_col;
      out_eof_q    <= stream_pix && last_col && last_row;
      frame_done_q <= stream_pix && last_col && last_row;
      if (in_valid) begin
        x1_q <= lb_top[col_q];
        x2_q <= lb_mid[col_q];
        x3_q <= in_data;
      end
    end
  end

  assign x1         = x1_q;
  assign x2         = x2_q;
  assign x3         = x3_q;
  assign out_valid  = out_valid_q;
  assign out_eol    = out_eol_q;
  assign out_eof    = out_eof_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Bench for conv_line_buffer: a 4x4 and a 5x3 instance driven against a frame-array
// reference model (output triple = image[r-2][c], image[r-1][c], image[r][c]).
module tb_conv_line_buffer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a = 1'b0, in_valid_a = 1'b0;
  logic [7:0] in_data_a = '0;
  logic [7:0] a_x1, a_x2, a_x3;
  logic       a_v, a_eol, a_eof, a_fd;

  logic       reset_b = 1'b0, in_valid_b = 1'b0;
  logic [7:0] in_data_b = '0;
  logic [7:0] b_x1, b_x2, b_x3;
  logic       b_v, b_eol, b_eof, b_fd;

  conv_line_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .COL_W(2), .ROW_W(2)) dut_a (
    .clock(clock), .reset(reset_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .x1(a_x1), .x2(a_x2), .x3(a_x3), .out_valid(a_v), .out_eol(a_eol),
    .out_eof(a_eof), .frame_done(a_fd)
  );

  conv_line_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .COL_W(3), .ROW_W(2)) dut_b (
    .clock(clock), .reset(reset_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .x1(b_x1), .x2(b_x2), .x3(b_x3), .out_valid(b_v), .out_eol(b_eol),
    .out_eof(b_eof), .frame_done(b_fd)
  );

  // Reference model state, one set per instance (k=0: 4x4, k=1: 5x3).
  logic [7:0] img [2][8][8];
  int         mr [2];
  int         mc [2];
  logic [7:0] e_x1 [2], e_x2 [2], e_x3 [2];
  bit         e_v [2], e_eol [2], e_eof [2], e_fd [2], e_known [2];

  // Packed {x1,x2,x3,valid,eol,eof,frame_done} for the instance last stepped.
  logic [27:0] obs, expv, msk;
  logic [23:0] ref_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int wid(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int hgt(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic step(input int k, input bit rst, input bit v, input logic [7:0] d);
    if (k == 0) begin
      reset_a = rst; in_valid_a = v; in_data_a = d; reset_b = 1'b0; in_valid_b = 1'b0;
    end else begin
      reset_b = rst; in_valid_b = v; in_data_b = d; reset_a = 1'b0; in_valid_a = 1'b0;
    end
    @(posedge clock);
    #1;
    if (rst) begin
      e_x1[k] = '0; e_x2[k] = '0; e_x3[k] = '0;
      e_v[k] = 0; e_eol[k] = 0; e_eof[k] = 0; e_fd[k] = 0; e_known[k] = 1;
      mr[k] = 0; mc[k] = 0;
    end else if (v) begin
      img[k][mr[k]][mc[k]] = d;
      if (mr[k] >= 2) begin
        e_x1[k] = img[k][mr[k]-2][mc[k]];
        e_x2[k] = img[k][mr[k]-1][mc[k]];
        e_x3[k] = d;
        e_v[k]   = 1;
        e_eol[k] = (mc[k] == wid(k) - 1);
        e_eof[k] = e_eol[k] && (mr[k] == hgt(k) - 1);
        e_fd[k]  = e_eof[k];
        e_known[k] = 1;
      end else begin
        e_v[k] = 0; e_eol[k] = 0; e_eof[k] = 0; e_fd[k] = 0; e_known[k] = 0;
      end
      mc[k]++;
      if (mc[k] == wid(k)) begin
        mc[k] = 0;
        mr[k] = (mr[k] == hgt(k) - 1) ? 0 : mr[k] + 1;
      end
    end else begin
      e_v[k] = 0; e_eol[k] = 0; e_eof[k] = 0; e_fd[k] = 0;
    end
    expv = {e_x1[k], e_x2[k], e_x3[k], e_v[k], e_eol[k], e_eof[k], e_fd[k]};
    obs  = (k == 0) ? {a_x1, a_x2, a_x3, a_v, a_eol, a_eof, a_fd}
                    : {b_x1, b_x2, b_x3, b_v, b_eol, b_eof, b_fd};
    // Pixel registers during FILL carry no meaning; only the flags are compared there.
    msk  = e_known[k] ? '1 : 28'hF;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(k, 1'b1, 1'b1, 8'hFF);
      if (obs !== 28'h0) $display("FAIL reset_state[%0d]: got %h want %h", k, obs, 28'h0);
      else n_pass++;
      n_checks++;
      step(k, 1'b0, 1'b0, 8'h00);
      if (obs !== 28'h0) $display("FAIL post_reset_idle[%0d]: got %h want %h", k, obs, 28'h0);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_fill_stream();
    int nv = 0;
    int eol_bits = 0;
    int fill_valid = 0;
    ref_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1'b0, 1'b1, 8'(16 * r + c));
        if ((obs & msk) !== (expv & msk)) $display("FAIL stream_model (%0d,%0d): got %h want %h", r, c, obs, expv);
        else n_pass++;
        n_checks++;
        if (r < 2 && obs[3]) fill_valid++;
        if (obs[3]) begin
          nv++;
          ref_q.push_back(obs[27:4]);
          if (obs[2]) eol_bits |= (1 << nv);
        end
        if (r == 2 && c == 0) begin
          if (obs[27:3] !== {8'h00, 8'h10, 8'h20, 1'b1}) $display("FAIL first_triple: got %h want %h", obs[27:3], {8'h00, 8'h10, 8'h20, 1'b1});
          else n_pass++;
          n_checks++;
        end
        if (r == 3 && c == 3) begin
          if (obs !== {8'h13, 8'h23, 8'h33, 4'hF}) $display("FAIL last_triple: got %h want %h", obs, {8'h13, 8'h23, 8'h33, 4'hF});
          else n_pass++;
          n_checks++;
        end
      end
    end
    if (fill_valid !== 0) $display("FAIL fill_no_valid: got %0d want 0", fill_valid);
    else n_pass++;
    n_checks++;
    if (nv !== 8) $display("FAIL valid_count: got %0d want 8", nv);
    else n_pass++;
    n_checks++;
    if (eol_bits !== ((1 << 4) | (1 << 8))) $display("FAIL eol_positions: got %h want %h", eol_bits, (1 << 4) | (1 << 8));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_bubbles();
    logic [23:0] got_q [$];
    int bad = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1'b0, 1'b1, 8'(16 * r + c));
        if ((obs & msk) !== (expv & msk)) $display("FAIL bubble_pixel (%0d,%0d): got %h want %h", r, c, obs, expv);
        else n_pass++;
        n_checks++;
        if (obs[3]) got_q.push_back(obs[27:4]);
        step(0, 1'b0, 1'b0, 8'hEE);
        if ((obs & msk) !== (expv & msk)) $display("FAIL bubble_idle (%0d,%0d): got %h want %h", r, c, obs, expv);
        else n_pass++;
        n_checks++;
      end
    end
    if (got_q.size() !== ref_q.size()) $display("FAIL bubble_count: got %0d want %0d", got_q.size(), ref_q.size());
    else n_pass++;
    n_checks++;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) if (got_q[i] !== ref_q[i]) bad++;
    if (bad !== 0) $display("FAIL bubble_sequence: got %0d differing triples want 0", bad);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid_frame();
    int early_valid = 0;
    for (int i = 0; i < 9; i++) step(0, 1'b0, 1'b1, 8'(16 * (i / 4) + (i % 4)));
    step(0, 1'b1, 1'b1, 8'h21);
    if (obs !== 28'h0) $display("FAIL mid_reset_state: got %h want %h", obs, 28'h0);
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b0, 1'b1, 8'(8'h80 + 16 * (i / 4) + (i % 4)));
      if ((obs & msk) !== (expv & msk)) $display("FAIL restart_model %0d: got %h want %h", i, obs, expv);
      else n_pass++;
      n_checks++;
      if (i < 8 && obs[3]) early_valid++;
      if (i == 8) begin
        if (obs[27:3] !== {8'h80, 8'h90, 8'hA0, 1'b1}) $display("FAIL restart_first: got %h want %h", obs[27:3], {8'h80, 8'h90, 8'hA0, 1'b1});
        else n_pass++;
        n_checks++;
      end
    end
    if (early_valid !== 0) $display("FAIL restart_early_valid: got %0d want 0", early_valid);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int early_valid = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        step(0, 1'b0, 1'b1, 8'(64 * f + 16 * (i / 4) + (i % 4)));
        if ((obs & msk) !== (expv & msk)) $display("FAIL b2b_model f%0d p%0d: got %h want %h", f, i, obs, expv);
        else n_pass++;
        n_checks++;
        if (f == 1 && i < 8 && obs[3]) early_valid++;
        if (f == 1 && i == 8) begin
          if (obs[27:3] !== {8'h40, 8'h50, 8'h60, 1'b1}) $display("FAIL b2b_first: got %h want %h", obs[27:3], {8'h40, 8'h50, 8'h60, 1'b1});
          else n_pass++;
          n_checks++;
        end
      end
    end
    if (early_valid !== 0) $display("FAIL b2b_early_valid: got %0d want 0", early_valid);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_param_geometry();
    int nv = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        step(1, 1'b0, 1'b1, 8'(16 * r + c));
        if ((obs & msk) !== (expv & msk)) $display("FAIL geom_model (%0d,%0d): got %h want %h", r, c, obs, expv);
        else n_pass++;
        n_checks++;
        if (obs[3]) nv++;
        if (r == 2 && c == 0) begin
          if (obs[27:3] !== {8'h00, 8'h10, 8'h20, 1'b1}) $display("FAIL geom_wrap: got %h want %h", obs[27:3], {8'h00, 8'h10, 8'h20, 1'b1});
          else n_pass++;
          n_checks++;
        end
        if (r == 2 && c == 4) begin
          if (obs !== {8'h04, 8'h14, 8'h24, 4'hF}) $display("FAIL geom_eof: got %h want %h", obs, {8'h04, 8'h14, 8'h24, 4'hF});
          else n_pass++;
          n_checks++;
        end
      end
    end
    if (nv !== 5) $display("FAIL geom_valid_count: got %0d want 5", nv);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 400; i++) begin
        step(k, ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        if ((obs & msk) !== (expv & msk)) $display("FAIL random[%0d] step %0d: got %h want %h", k, i, obs, expv);
        else n_pass++;
        n_checks++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mr[k] = 0; mc[k] = 0; e_known[k] = 0;
      e_x1[k] = '0; e_x2[k] = '0; e_x3[k] = '0;
      e_v[k] = 0; e_eol[k] = 0; e_eof[k] = 0; e_fd[k] = 0;
    end
    test_reset();
    test_fill_stream();
    test_bubbles();
    test_reset_mid_frame();
    test_back_to_back();
    test_param_geometry();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Upstream feeder for the 3x3 convolution array; stands in for the free-running row source.
- Accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle.
- Stores the two previous image rows in on-chip line memories.
- Emits three vertically aligned pixels per column (rows r-2, r-1, r) on x1/x2/x3, plus valid and line/frame markers for the MAC chain.

Parameters:
- IMG_WIDTH, 128, pixels per row (>=3)
- IMG_HEIGHT, 128, rows per frame (>=3)
- COL_W, 7, column counter width, ceil(log2(IMG_WIDTH))
- ROW_W, 7, row counter width, ceil(log2(IMG_HEIGHT))

Ports:
- clock  input  1  single system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data carries a pixel this cycle
- in_data  input  8  unsigned pixel, raster order
- x1  output  8  pixel at row r-2, current column (top kernel row)
- x2  output  8  pixel at row r-1, current column (middle kernel row)
- x3  output  8  pixel at row r, current column (bottom kernel row)
- out_valid  output  1  x1/x2/x3 form a valid column triple
- out_eol  output  1  valid triple is last column of its row
- out_eof  output  1  valid triple is last column of last row
- frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Storage: two line RAMs, lb_top and lb_mid, each IMG_WIDTH x 8, addressed by column counter col. Contents are never cleared.
- Input acceptance: always accepted when in_valid=1; there is no backpressure. Cycles with in_valid=0 change nothing except that out_valid, out_eol and out_eof deassert.
- Per accepted pixel p at (row, col), on the same edge:
  - Read old T=lb_top[col] and M=lb_mid[col].
  - Write lb_top[col]<=M and lb_mid[col]<=p.
  - Register x1<=T, x2<=M, x3<=p.
  - Read-before-write within the cycle is required: registered or LUT RAM with old-data read.
- Latency: exactly 1 cycle from accepted pixel to x1/x2/x3/out_valid. Outputs hold their last values while out_valid=0.
- FSM states: FILL, STREAM.
  - FILL: row<2; out_valid=0 for accepted pixels. After the last column of row 1, go to STREAM.
  - STREAM: out_valid=1 for every accepted pixel, registered.
  - Last column of row IMG_HEIGHT-1: out_eof=1, frame_done pulses on the same cycle as that output, row<=0, return to FILL.
- Counters:
  - col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0.
  - row increments on col wrap and wraps IMG_HEIGHT-1 -> 0.
  - Non-power-of-2 widths must wrap at the parameter, not at 2^COL_W.
- out_eol=1 with out_valid when the output column is IMG_WIDTH-1. out_eof implies out_eol.
- Reset values: x1=x2=x3=0, out_valid=0, out_eol=0, out_eof=0, frame_done=0, col=0, row=0, state=FILL.
- Reset mid-frame: counters and state return to initial values on the next edge. Stale RAM contents are masked because the next two rows pass through FILL. No spurious out_valid in the cycle after reset deasserts.
- Reset has priority over in_valid on the same edge; that pixel is discarded.
- Back-to-back frames: pixel 0 of the next frame may arrive the cycle after the last pixel of the previous frame. It is handled in FILL with no gap required.
- Downstream contract: the consumer zero-extends x1..x3 to 9-bit signed. It must qualify with out_valid and treat eol as a horizontal window boundary.

Test Plan:
- Setup for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4; pixel value = 16*row+col, in_valid held high.
  - Scenario 1: first 8 pixels -> out_valid=0 throughout.
  - Scenario 1, continued: pixel (2,0) -> next cycle x1=0x00, x2=0x10, x3=0x20, out_valid=1.
- Continuous frame: pixel (3,3) -> x1=0x13, x2=0x23, x3=0x33, out_valid=out_eol=out_eof=1, frame_done=1. Exactly 8 valid outputs per frame; out_eol on outputs 4 and 8.
- Bubbles: same frame with in_valid toggling 1,0,1,0 -> identical valid-output sequence. out_valid=0 on idle cycles; x1..x3 hold.
- Reset mid-frame: assert reset during pixel (2,1), then restart a frame with value = 0x80+16*row+col.
  - Required: no out_valid until new pixel (2,0).
  - Then x1=0x80, x2=0x90, x3=0xA0; no stale 0x0x/0x1x values appear.
- Back-to-back frames: two consecutive frames, second offset +0x40 -> second-frame first output x1=0x40, x2=0x50, x3=0x60. No valid output during the second frame's rows 0-1.
- Parameter check: IMG_WIDTH=5, IMG_HEIGHT=3 -> col wraps at 4 (not 7), 5 valid outputs, out_eof on column 4 with x3=0x24.
